mips_load_store_unit: RTL
=========================

// Module: mips_load_store_unit
// PURPOSE
//   Core-side initiator for the MIPS data memory port. Accepts one load/store per handshake from the
//   MEM stage and drives a word-addressed memory request with byte enables. Returns sign- or
//   zero-extended load data and implements the ll/sc link reservation. Sits between the pipeline
//   MEM stage and the data memory responder.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles to wait for mem_ack before abandoning the access (min 2)
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous reset, active low
//   req_valid    in   1   core presents an access
//   req_ready    out  1   LSU idle, can accept; transfer when req_valid & req_ready
//   opcode       in   6   MIPS opcode: lb/lh/lw/lbu/lhu/sb/sh/sw/ll/sc
//   addr         in   32  byte address (base + offset)
//   store_data   in   32  rt value for stores
//   resp_valid   out  1   one-cycle pulse: access complete
//   load_data    out  32  extended load result; sc: 1 = success, 0 = fail
//   resp_err     out  1   valid with resp_valid: timeout or illegal opcode
//   mem_req      out  1   request to memory, held until mem_ack
//   mem_we       out  1   1 = write
//   mem_addr     out  30  word address = addr[31:2]
//   mem_be       out  4   byte enables, lane0 = bits[7:0] (little-endian lanes)
//   mem_wdata    out  32  store data replicated into the addressed lane(s)
//   mem_ack      in   1   memory done; mem_rdata valid in the same cycle
//   mem_rdata    in   32  read word
//   misalign_exc out  1   only with LSU_MISALIGN_TRAP_EN; valid with resp_valid
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; resp_valid, resp_err, mem_req, mem_we=0; mem_addr, mem_be,
//   mem_wdata, load_data=0; link_valid=0; timeout counter=0. Reset mid-access drops mem_req
//   immediately. No response is produced.
// - FSM IDLE -> REQ -> RESP -> IDLE. IDLE: on handshake, latch opcode and addr[1:0]; compute
//   be/wdata; go to REQ. REQ: mem_req=1 with stable outputs until mem_ack; capture rdata; go to RESP.
//   RESP: resp_valid=1 for exactly one cycle; req_ready=0 in REQ and RESP.
// - Latency: handshake at cycle 0, mem_req from cycle 1, ack at cycle k>=1, resp_valid at k+1.
//   Minimum is 3 cycles per access; no overlap.
// - Lanes: byte be=1<<addr[1:0], wdata={4{sd[7:0]}}. Half be=addr[1]?1100:0011,
//   wdata={2{sd[15:0]}}. Word be=1111.
// - Loads: select the lane by the latched addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend;
//   lw/ll take the full word.
// - ll: performs a load; sets link_valid=1 and link_addr=addr[31:2] at mem_ack.
// - sc: if link_valid && link_addr==addr[31:2], write the word, then load_data=1. Otherwise no
//   memory access: IDLE->RESP directly with load_data=0. Any sc clears link_valid.
// - Any sb/sh/sw whose word matches link_addr clears link_valid at mem_ack.
// - Illegal opcode: no memory access; RESP next cycle with resp_err=1, load_data=0.
// - Timeout: counter resets on entering REQ and increments each REQ cycle without ack. When it
//   reaches TIMEOUT_CYCLES, drop mem_req and go to RESP with resp_err=1, load_data=0, and no link
//   update. An ack arriving in the same cycle as expiry wins.
// CONFIGURATION
// - LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1, or word/ll/sc with addr[1:0]!=0,
//   skips memory and responds next cycle with misalign_exc=1, resp_err=1, load_data=0, and no
//   link change.
// - Macro undefined: no misalign_exc port. Low address bits are ignored for lane selection
//   (half uses addr[1], word uses the whole word).
// STRUCTURE
// - Shared package mips_mem_pkg: opcode localparams (OP_LB..OP_SC), state encoding,
//   access-size enum.
// - One sub-module mips_lsu_align: combinational be/wdata generation and load extract/extend.
//   FSM, counter and link register stay in the top.
// TESTING
// - sw addr=0x10 sd=0xDEADBEEF, ack after 2 cycles -> mem_addr=4, be=1111, wdata=DEADBEEF,
//   resp_valid at cycle 4.
// - lb addr=0x13, rdata=0x80FF0000 -> be=1000, load_data=0xFFFFFF80.
//   lbu at the same address -> 0x00000080.
// - lh addr=0x12 rdata=0x8001xxxx -> 0xFFFF8001; lhu -> 0x00008001.
// - ll 0x20; sc 0x20 -> write issued, load_data=1. Second sc 0x20 -> no mem_req, load_data=0.
// - ll 0x20; sw 0x20; sc 0x20 -> load_data=0. Also: mem_ack never arrives -> resp_err after 16
//   REQ cycles; assert rst_n mid-REQ -> mem_req=0 at once.
// - With LSU_MISALIGN_TRAP_EN: lw 0x11 -> no mem_req, misalign_exc=1, resp_err=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS load/store unit.
// Contents: opcodes, FSM states, access sizes and the opcode decoder.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  typedef struct packed {
    logic      legal;
    logic      is_store;
    logic      is_ll;
    logic      is_sc;
    logic      sext;
    acc_size_e size;
  } op_info_t;

  // sc is treated as a word store; its success value is produced by the top.
  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info.legal    = 1'b1;
    info.is_store = 1'b0;
    info.is_ll    = 1'b0;
    info.is_sc    = 1'b0;
    info.sext     = 1'b0;
    info.size     = SZ_WORD;
    case (op)
      OP_LB:  begin info.sext = 1'b1; info.size = SZ_BYTE; end
      OP_LH:  begin info.sext = 1'b1; info.size = SZ_HALF; end
      OP_LW:  info.size = SZ_WORD;
      OP_LBU: info.size = SZ_BYTE;
      OP_LHU: info.size = SZ_HALF;
      OP_SB:  begin info.is_store = 1'b1; info.size = SZ_BYTE; end
      OP_SH:  begin info.is_store = 1'b1; info.size = SZ_HALF; end
      OP_SW:  info.is_store = 1'b1;
      OP_LL:  info.is_ll = 1'b1;
      OP_SC:  begin info.is_store = 1'b1; info.is_sc = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Lane steering for the load/store unit: store byte enables and replicated write data,
// and load lane extraction with sign or zero extension.
module mips_lsu_align
  import mips_mem_pkg::*;
(
  input  acc_size_e   st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  acc_size_e   ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sext,
  input  logic [31:0] rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (st_size)
      SZ_BYTE: begin
        be    = 4'b0001 << st_addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    ld_byte  = rdata[8*ld_addr_lo +: 8];
    ld_half  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ld_value = rdata;
    case (ld_size)
      SZ_BYTE: ld_value = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_value = rdata;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS data-memory load/store unit: one access at a time, ll/sc link register, ack timeout.
// Defining LSU_MISALIGN_TRAP_EN adds misalign_exc and traps unaligned half/word accesses.
module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        link_valid_q, link_valid_d;
  logic [29:0] link_addr_q, link_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_size_e   size_q, size_d;
  logic        sext_q, sext_d;
  logic        is_store_q, is_store_d;
  logic        is_ll_q, is_ll_d;
  logic        is_sc_q, is_sc_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  op_info_t         dec;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_value;
  logic             misalign_hit;
  logic             link_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign dec      = decode_op(opcode);
  assign link_hit = link_valid_q && (link_addr_q == addr[31:2]);
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (dec.size)
      SZ_HALF: misalign_hit = addr[0];
      SZ_WORD: misalign_hit = |addr[1:0];
      default: misalign_hit = 1'b0;
    endcase
  end
`else
  assign misalign_hit = 1'b0;
`endif

  mips_lsu_align u_align (
    .st_size    (dec.size),
    .st_addr_lo (addr[1:0]),
    .store_data (store_data),
    .be         (st_be),
    .wdata      (st_wdata),
    .ld_size    (size_q),
    .ld_addr_lo (addr_lo_q),
    .ld_sext    (sext_q),
    .rdata      (mem_rdata),
    .ld_value   (ld_value)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    load_data_d  = load_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    sext_d       = sext_q;
    is_store_d   = is_store_q;
    is_ll_d      = is_ll_q;
    is_sc_d      = is_sc_q;
    addr_lo_d    = addr_lo_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          resp_err_d  = 1'b0;
          load_data_d = 32'd0;
          size_d      = dec.size;
          sext_d      = dec.sext;
          is_store_d  = dec.is_store;
          is_ll_d     = dec.is_ll;
          is_sc_d     = dec.is_sc;
          addr_lo_d   = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_d  = 1'b0;
`endif
          if (!dec.legal || misalign_hit) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d   = dec.legal;
`endif
          end else if (dec.is_sc && !link_hit) begin
            // A failed sc never touches memory but still consumes the reservation.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            link_valid_d = 1'b0;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = dec.is_store;
            mem_addr_d  = addr[31:2];
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
            cnt_d       = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          if (is_sc_q) begin
            load_data_d  = 32'd1;
            link_valid_d = 1'b0;
          end else if (is_store_q) begin
            load_data_d = 32'd0;
            if (mem_addr_q == link_addr_q) begin
              link_valid_d = 1'b0;
            end
          end else begin
            load_data_d = ld_value;
            if (is_ll_q) begin
              link_valid_d = 1'b1;
              link_addr_d  = mem_addr_q;
            end
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          load_data_d  = 32'd0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          cnt_d        = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_data_q  <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 30'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      link_valid_q <= 1'b0;
      link_addr_q  <= 30'd0;
      cnt_q        <= '0;
      size_q       <= SZ_WORD;
      sext_q       <= 1'b0;
      is_store_q   <= 1'b0;
      is_ll_q      <= 1'b0;
      is_sc_q      <= 1'b0;
      addr_lo_q    <= 2'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      load_data_q  <= load_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      is_store_q   <= is_store_d;
      is_ll_q      <= is_ll_d;
      is_sc_q      <= is_sc_d;
      addr_lo_q    <= addr_lo_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign load_data  = load_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_exc = misalign_q;
`endif

endmodule
